// File: rtl/scr1_imem_responder_if.sv
// Instruction fetch bus between a core (master) and the imem responder (slave).
interface scr1_imem_responder_if;
  logic        imem_req;
  logic        imem_cmd;
  logic [31:0] imem_addr;
  logic        imem_req_ack;
  logic [31:0] imem_rdata;
  logic [1:0]  imem_resp;

  modport master (
    output imem_req, imem_cmd, imem_addr,
    input  imem_req_ack, imem_rdata, imem_resp
  );

  modport slave (
    input  imem_req, imem_cmd, imem_addr,
    output imem_req_ack, imem_rdata, imem_resp
  );
endinterface

// File: rtl/scr1_imem_responder.sv
// Instruction memory responder: fixed-latency pipelined fetch responses from a
// preloadable word store, with acceptance and error counters.
module scr1_imem_responder #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned LATENCY   = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  scr1_imem_responder_if.slave        imem,
  input  logic                        stall_i,
  input  logic                        load_we,
  input  logic [31:0]                 load_addr,
  input  logic [31:0]                 load_data,
  output logic [31:0]                 acc_cnt,
  output logic [31:0]                 err_cnt
);

  localparam int unsigned AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  typedef enum logic [1:0] {
    RESP_IDLE = 2'b00,
    RESP_RDY  = 2'b01,
    RESP_ER   = 2'b10
  } resp_e;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] data;
  } stage_t;

  logic [31:0] mem [MEM_WORDS];

  stage_t      stage_q [LATENCY];
  stage_t      stage_d [LATENCY];
  logic [31:0] acc_cnt_q, acc_cnt_d;
  logic [31:0] err_cnt_q, err_cnt_d;

  logic        accept;
  logic [31:0] rd_idx;
  logic        rd_err;
  logic [31:0] ld_idx;
  logic        ld_ok;
  stage_t      out_stage;
  resp_e       resp;

  // Request acceptance, classification and memory read in the acceptance cycle
  always_comb begin
    imem.imem_req_ack = rst_n & ~stall_i;
    accept            = imem.imem_req & imem.imem_req_ack;
    rd_idx            = (imem.imem_addr - BASE_ADDR) >> 2;
    rd_err            = imem.imem_cmd | (rd_idx >= MEM_WORDS);
    ld_idx            = (load_addr - BASE_ADDR) >> 2;
    ld_ok             = ld_idx < MEM_WORDS;
  end

  // Next-state of the response pipeline and counters
  always_comb begin
    stage_d[0].valid = accept;
    stage_d[0].err   = rd_err;
    stage_d[0].data  = (accept && !rd_err) ? mem[rd_idx[AW-1:0]] : '0;
    for (int unsigned i = 1; i < LATENCY; i++) begin
      stage_d[i] = stage_q[i-1];
    end
    acc_cnt_d = acc_cnt_q + 32'(accept);
    err_cnt_d = err_cnt_q + 32'(resp == RESP_ER);
  end

  // Response decode from the final pipeline stage
  always_comb begin
    out_stage = stage_q[LATENCY-1];
    resp      = RESP_IDLE;
    if (out_stage.valid) begin
      resp = out_stage.err ? RESP_ER : RESP_RDY;
    end
    imem.imem_resp  = resp;
    imem.imem_rdata = (out_stage.valid && !out_stage.err) ? out_stage.data : '0;
    acc_cnt         = acc_cnt_q;
    err_cnt         = err_cnt_q;
  end

  // Pipeline and counter registers; reset discards everything in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        stage_q[i] <= '0;
      end
      acc_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        stage_q[i] <= stage_d[i];
      end
      acc_cnt_q <= acc_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Preload port; array is not reset so contents survive rst_n. The read
  // above is combinational on the pre-edge contents, giving read-before-write.
  always_ff @(posedge clk) begin
    if (load_we && ld_ok) begin
      mem[ld_idx[AW-1:0]] <= load_data;
    end
  end

endmodule
